// File: rtl/fp32_div_seq.sv
// Sequential IEEE-754 binary32 divider: res = a / b, radix-2 restoring mantissa
// divider behind a start/done handshake, RNE rounding, subnormals in and out.
module fp32_div_seq #(
  parameter int WIDTH = 32,
  parameter int QBITS = 26
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res
);

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIV, S_ROUND, S_DONE} state_t;

  typedef struct packed {
    logic        zero;
    logic        inf;
    logic        nan;
    logic [23:0] man;   // normalised, bit23 set for any finite nonzero operand
    logic [9:0]  ex;    // biased exponent, two's complement (subnormals go below 1)
  } opnd_t;

  localparam logic [31:0] CANON_NAN = 32'hFFFF_FFFF;

  function automatic logic [4:0] lz_shift(input logic [22:0] f);
    logic [4:0] s;
    s = 5'd0;
    for (int i = 0; i < 23; i++) begin
      if (f[i]) s = 5'(23 - i);
    end
    return s;
  endfunction

  function automatic opnd_t classify(input logic [31:0] x);
    opnd_t      o;
    logic [4:0] s;
    logic [23:0] m;
    s      = lz_shift(x[22:0]);
    m      = {1'b0, x[22:0]};
    o.zero = (x[30:23] == 8'h00) && (x[22:0] == 23'd0);
    o.inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    o.nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    if (x[30:23] == 8'h00) begin
      o.man = m << s;
      o.ex  = 10'd1 - {5'd0, s};
    end else begin
      o.man = {1'b1, x[22:0]};
      o.ex  = {2'b00, x[30:23]};
    end
    return o;
  endfunction

  state_t              r_state, w_next;
  logic [WIDTH-1:0]    r_a, r_b;
  logic                r_sign;
  logic signed [9:0]   r_e;
  logic [23:0]         r_mb;
  logic [24:0]         r_rem;
  logic [QBITS-1:0]    r_q;
  logic [4:0]          r_cnt;
  logic [WIDTH-1:0]    r_pack;
  logic [WIDTH-1:0]    r_res;
  logic                r_done;

  opnd_t               w_opa, w_opb;
  logic                w_sign;
  logic signed [9:0]   w_e_unp;
  logic                w_special;
  logic [WIDTH-1:0]    w_special_res;
  logic                w_ge;
  logic [24:0]         w_diff;
  logic                w_accept;

  logic [QBITS-1:0]    w_qn;
  logic signed [9:0]   w_en;
  logic signed [9:0]   w_shf;
  logic [4:0]          w_sh;
  logic [49:0]         w_wide;
  logic [23:0]         w_sig;
  logic                w_guard, w_sticky, w_inc;
  logic [7:0]          w_ed;
  logic [30:0]         w_mag;
  logic [WIDTH-1:0]    w_round_res;

  // Operand classification and special-value results.
  assign w_opa   = classify(r_a);
  assign w_opb   = classify(r_b);
  assign w_sign  = r_a[31] ^ r_b[31];
  assign w_e_unp = $signed(w_opa.ex) - $signed(w_opb.ex) + 10'sd127;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_special     = 1'b1;
    w_special_res = CANON_NAN;
    if (w_opa.nan || w_opb.nan || (w_opa.zero && w_opb.zero) || (w_opa.inf && w_opb.inf))
      w_special_res = CANON_NAN;
    else if (w_opb.zero || w_opa.inf)
      w_special_res = {w_sign, 8'hFF, 23'd0};
    else if (w_opb.inf || w_opa.zero)
      w_special_res = {w_sign, 31'd0};
    else
      w_special = 1'b0;
  end

  // One restoring-division step; remainder stays below 2*mb so 25 bits suffice.
  assign w_ge   = (r_rem >= {1'b0, r_mb});
  assign w_diff = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;

  // Normalise, denormalise if the exponent underflows, then round to nearest even.
  always_comb begin
    w_qn = r_q;
    w_en = r_e;
    if (!r_q[QBITS-1]) begin
      w_qn = {r_q[QBITS-2:0], 1'b0};
      w_en = r_e - 10'sd1;
    end
    w_sig    = w_qn[25:2];
    w_guard  = w_qn[1];
    w_sticky = w_qn[0] | (|r_rem);
    w_ed     = w_en[7:0];
    w_shf    = 10'sd1 - w_en;
    w_sh     = 5'd0;
    w_wide   = {w_qn[25:1], 25'd0};
    if (w_en <= 10'sd0) begin
      w_sh     = (w_shf > 10'sd26) ? 5'd26 : w_shf[4:0];
      w_wide   = {w_qn[25:1], 25'd0} >> w_sh;
      w_sig    = w_wide[49:26];
      w_guard  = w_wide[25];
      w_sticky = w_sticky | (|w_wide[24:0]);
      w_ed     = 8'd0;
    end
    w_inc = w_guard & (w_sticky | w_sig[0]);
    // Carry out of the fraction lands in the exponent field (also subnormal -> min normal).
    w_mag = {w_ed, w_sig[22:0]} + {30'd0, w_inc};
    if (w_en >= 10'sd255) w_round_res = {r_sign, 8'hFF, 23'd0};
    else                  w_round_res = {r_sign, w_mag};
  end

  // FSM: state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // FSM: next state. A start in the o_done cycle is held off until the following cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start && !r_done) w_next = S_UNPACK;
      S_UNPACK: w_next = w_special ? S_DONE : S_DIV;
      S_DIV:    if (r_cnt == 5'(QBITS - 1)) w_next = S_ROUND;
      S_ROUND:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    w_accept = 1'b0;
    o_busy   = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_accept = i_start && !r_done;
        o_busy   = r_done;
      end
      default: o_busy = 1'b1;
    endcase
  end

  assign o_done = r_done;
  assign o_res  = r_res;

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sign <= 1'b0;
      r_e    <= '0;
      r_mb   <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_pack <= '0;
      r_res  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a <= i_a;
            r_b <= i_b;
          end
        end
        S_UNPACK: begin
          r_sign <= w_sign;
          r_e    <= w_e_unp;
          r_rem  <= {1'b0, w_opa.man};
          r_mb   <= w_opb.man;
          r_q    <= '0;
          r_cnt  <= '0;
          if (w_special) r_pack <= w_special_res;
        end
        S_DIV: begin
          r_rem <= {w_diff[23:0], 1'b0};
          r_q   <= {r_q[QBITS-2:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
        end
        S_ROUND: r_pack <= w_round_res;
        S_DONE:  r_res  <= r_pack;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_div_seq.sv
// Directed bench for fp32_div_seq: table of operand/result vectors plus handshake,
// back-to-back and mid-operation reset sequences.
module tb_fp32_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] res;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam int LAT_NORM = 29;
  localparam int LAT_SPEC = 2;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          special;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  fp32_div_seq dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (busy),
    .o_done  (done),
    .o_res   (res)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
    @(negedge clk);
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(posedge clk);
  endtask

  // Called right after the accept edge; returns in the o_done cycle (at the negedge).
  task automatic wait_done(input int inj, input logic [31:0] ia, input logic [31:0] ib,
                           output int lat, output bit busy_ok, output bit seen);
    lat     = 0;
    busy_ok = 1'b1;
    seen    = 1'b0;
    while (lat < 60) begin
      @(negedge clk);
      if (lat == 0) start = 1'b0;
      if (lat == inj) begin
        start = 1'b1;
        a     = ia;
        b     = ib;
      end else if (lat == inj + 1) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] exp, input bit special,
                        input int inj, input logic [31:0] ja, input logic [31:0] jb);
    int lat;
    bit busy_ok, seen;
    issue(ia, ib);
    wait_done(inj, ja, jb, lat, busy_ok, seen);
    check({name, " done seen"}, {31'd0, seen}, 32'd1);
    check({name, " res"}, res, exp);
    check({name, " latency"}, lat, special ? LAT_SPEC : LAT_NORM);
    check({name, " busy held"}, {31'd0, busy_ok}, 32'd1);
    @(negedge clk);
    check({name, " idle after"}, {29'd0, done, busy, (res === exp)}, 32'd1);
  endtask

  initial begin
    int  lat;
    bit  busy_ok, seen;
    bit  done_seen;

    vecs.push_back('{32'h40600000, 32'h3E000000, 32'h41E00000, 1'b0}); // 3.5 / 0.125
    vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0}); // 1/3, RNE up
    vecs.push_back('{32'h7F000000, 32'h3F000000, 32'h7F800000, 1'b0}); // overflow
    vecs.push_back('{32'h00000002, 32'h40000000, 32'h00000001, 1'b0}); // min subnormal
    vecs.push_back('{32'h00000001, 32'h40800000, 32'h00000000, 1'b0}); // 2^-151 -> 0
    vecs.push_back('{32'h00800000, 32'h40000000, 32'h00400000, 1'b0}); // min normal / 2
    vecs.push_back('{32'h00FFFFFF, 32'h40000000, 32'h00800000, 1'b0}); // subnormal tie rounds into normal
    vecs.push_back('{32'h00000001, 32'h40000000, 32'h00000000, 1'b0}); // 2^-150 tie to even 0
    vecs.push_back('{32'h00000001, 32'h7F000000, 32'h00000000, 1'b0}); // deep underflow
    vecs.push_back('{32'h40C00000, 32'hC0000000, 32'hC0400000, 1'b0}); // 6 / -2
    vecs.push_back('{32'h3F800000, 32'h00400000, 32'h7F000000, 1'b0}); // 1 / 2^-127
    vecs.push_back('{32'h40000000, 32'h00400000, 32'h7F800000, 1'b0}); // 2 / 2^-127 overflow
    vecs.push_back('{32'h40000000, 32'h00000000, 32'h7F800000, 1'b1}); // x/0
    vecs.push_back('{32'hC0000000, 32'h80000000, 32'h7F800000, 1'b1}); // -2/-0
    vecs.push_back('{32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1}); // 0/0
    vecs.push_back('{32'h7F800000, 32'hFF800000, 32'hFFFFFFFF, 1'b1}); // inf/inf
    vecs.push_back('{32'h3F800000, 32'hFF800000, 32'h80000000, 1'b1}); // 1/-inf
    vecs.push_back('{32'h7FC00000, 32'h3F800000, 32'hFFFFFFFF, 1'b1}); // NaN in
    vecs.push_back('{32'h80000000, 32'h40000000, 32'h80000000, 1'b1}); // -0/2
    vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b1}); // -inf/2

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset outputs", {done, busy, res[29:0]}, 32'd0);
    check("reset res", res, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].special,
             -1, 32'd0, 32'd0);

    // Start pulsed 5 cycles into an operation is dropped, first result unaffected.
    run_op("ignored start", 32'h40600000, 32'h3E000000, 32'h41E00000, 1'b0,
           5, 32'h3F800000, 32'h40400000);

    // Start raised in the o_done cycle is taken only if still high the next cycle.
    issue(32'h40600000, 32'h3E000000);
    wait_done(-1, 32'd0, 32'd0, lat, busy_ok, seen);
    check("b2b first res", res, 32'h41E00000);
    start = 1'b1;
    a     = 32'h40C00000;
    b     = 32'hC0000000;
    @(posedge clk);
    @(negedge clk);
    check("b2b not yet busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    wait_done(-1, 32'd0, 32'd0, lat, busy_ok, seen);
    check("b2b second res", res, 32'hC0400000);
    check("b2b second latency", lat, LAT_NORM);
    check("b2b busy held", {31'd0, busy_ok}, 32'd1);

    // Start only during the o_done cycle is not accepted.
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("done-cycle pulse dropped", {30'd0, busy, done}, 32'd0);

    // Reset in the middle of DIV aborts immediately, no o_done follows.
    issue(32'h40600000, 32'h3E000000);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort busy/done", {30'd0, busy, done}, 32'd0);
    check("abort res", res, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) done_seen = 1'b1;
    end
    check("no done after abort", {31'd0, done_seen}, 32'd0);

    run_op("fresh after reset", 32'h40600000, 32'h3E000000, 32'h41E00000, 1'b0,
           -1, 32'd0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
